// File: rtl/macload_csr_regs.sv
// macload_csr_regs: CSR bank for the MAC-load address generator.
// Holds activation/weight address, stride, rollback and skip registers, plus
// read-only counts of controller address updates. Software wins any same-cycle
// collision with the controller; software writes to address/skip registers
// pulse an active-low counter-reset strobe toward the controller.
module macload_csr_regs #(
  parameter logic [11:0] BASE_ADDR = 12'h7D0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sw_access_i,
  input  logic [11:0] sw_addr_i,
  input  logic [1:0]  sw_op_i,
  input  logic [31:0] sw_wdata_i,
  output logic [31:0] sw_rdata_o,
  output logic        sw_hit_o,
  input  logic [1:0]  hw_op_i,
  input  logic [11:0] hw_addr_i,
  input  logic [31:0] hw_wdata_i,
  output logic [31:0] a_address_o,
  output logic [31:0] w_address_o,
  output logic [31:0] a_stride_o,
  output logic [31:0] w_stride_o,
  output logic [31:0] a_rollback_o,
  output logic [31:0] w_rollback_o,
  output logic [31:0] a_skip_o,
  output logic [31:0] w_skip_o,
  output logic        csr_a_rstn_o,
  output logic        csr_w_rstn_o
);

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [11:0] OFF_A_ADDR = 12'd0;
  localparam logic [11:0] OFF_W_ADDR = 12'd1;
  localparam logic [11:0] OFF_A_SKIP = 12'd6;
  localparam logic [11:0] OFF_W_SKIP = 12'd7;
  localparam logic [11:0] OFF_A_CNT  = 12'd8;
  localparam logic [11:0] OFF_W_CNT  = 12'd9;
  localparam logic [11:0] NUM_REGS   = 12'd10;

  // Offsets 0..7 are the writable registers; counts are kept separately.
  logic [31:0] csr_q [0:7];
  logic [31:0] a_cnt_q;
  logic [31:0] w_cnt_q;
  logic        a_rstn_q;
  logic        w_rstn_q;

  logic [11:0] sw_off;
  logic [11:0] hw_off;
  logic        sw_active;
  logic        sw_wr_en;
  logic [31:0] sw_cur;
  logic [31:0] sw_new;
  logic        hw_valid;
  logic        hw_a_en;
  logic        hw_w_en;
  logic        a_strobe;
  logic        w_strobe;

  // Offsets wrap modulo 4096, so addresses below BASE_ADDR land far out of range.
  assign sw_off    = sw_addr_i - BASE_ADDR;
  assign hw_off    = hw_addr_i - BASE_ADDR;
  assign sw_hit_o  = (sw_off < NUM_REGS);
  assign sw_active = sw_access_i && sw_hit_o && (sw_op_i != OP_NONE);
  assign sw_wr_en  = sw_active && (sw_off < OFF_A_CNT);

  // Read mux returns the pre-update value; out of range reads return 0.
  always_comb begin
    sw_cur = '0;
    if (sw_off < OFF_A_CNT)
      sw_cur = csr_q[sw_off[2:0]];
    else if (sw_off == OFF_A_CNT)
      sw_cur = a_cnt_q;
    else if (sw_off == OFF_W_CNT)
      sw_cur = w_cnt_q;
  end

  assign sw_rdata_o = sw_cur;

  // Software read-modify-write operand.
  always_comb begin
    sw_new = sw_cur;
    case (sw_op_i)
      OP_WRITE: sw_new = sw_wdata_i;
      OP_SET:   sw_new = sw_cur | sw_wdata_i;
      OP_CLEAR: sw_new = sw_cur & ~sw_wdata_i;
      default:  sw_new = sw_cur;
    endcase
  end

  // Controller updates only the two address registers and yields to software.
  assign hw_valid = (hw_op_i == OP_WRITE);
  assign hw_a_en  = hw_valid && (hw_off == OFF_A_ADDR) && !(sw_active && sw_off == OFF_A_ADDR);
  assign hw_w_en  = hw_valid && (hw_off == OFF_W_ADDR) && !(sw_active && sw_off == OFF_W_ADDR);

  assign a_strobe = sw_active && ((sw_off == OFF_A_ADDR) || (sw_off == OFF_A_SKIP));
  assign w_strobe = sw_active && ((sw_off == OFF_W_ADDR) || (sw_off == OFF_W_SKIP));

  // Register bank, update counters and counter-reset strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) csr_q[i] <= '0;
      a_cnt_q  <= '0;
      w_cnt_q  <= '0;
      a_rstn_q <= 1'b0;
      w_rstn_q <= 1'b0;
    end else begin
      if (sw_wr_en) csr_q[sw_off[2:0]] <= sw_new;
      if (hw_a_en) begin
        csr_q[0] <= hw_wdata_i;
        a_cnt_q  <= a_cnt_q + 32'd1;
      end
      if (hw_w_en) begin
        csr_q[1] <= hw_wdata_i;
        w_cnt_q  <= w_cnt_q + 32'd1;
      end
      a_rstn_q <= !a_strobe;
      w_rstn_q <= !w_strobe;
    end
  end

  assign a_address_o  = csr_q[0];
  assign w_address_o  = csr_q[1];
  assign a_stride_o   = csr_q[2];
  assign w_stride_o   = csr_q[3];
  assign a_rollback_o = csr_q[4];
  assign w_rollback_o = csr_q[5];
  assign a_skip_o     = csr_q[6];
  assign w_skip_o     = csr_q[7];
  assign csr_a_rstn_o = a_rstn_q;
  assign csr_w_rstn_o = w_rstn_q;

endmodule

// File: tb/tb_macload_csr_regs.sv
// tb_macload_csr_regs: directed test of the MAC-load CSR bank.
module tb_macload_csr_regs;

  localparam logic [11:0] BASE = 12'h7D0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sw_access_i;
  logic [11:0] sw_addr_i;
  logic [1:0]  sw_op_i;
  logic [31:0] sw_wdata_i;
  logic [31:0] sw_rdata_o;
  logic        sw_hit_o;
  logic [1:0]  hw_op_i;
  logic [11:0] hw_addr_i;
  logic [31:0] hw_wdata_i;
  logic [31:0] a_address_o, w_address_o, a_stride_o, w_stride_o;
  logic [31:0] a_rollback_o, w_rollback_o, a_skip_o, w_skip_o;
  logic        csr_a_rstn_o, csr_w_rstn_o;

  int tests = 0;
  int fails = 0;

  macload_csr_regs #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sw_access_i(sw_access_i), .sw_addr_i(sw_addr_i), .sw_op_i(sw_op_i),
    .sw_wdata_i(sw_wdata_i), .sw_rdata_o(sw_rdata_o), .sw_hit_o(sw_hit_o),
    .hw_op_i(hw_op_i), .hw_addr_i(hw_addr_i), .hw_wdata_i(hw_wdata_i),
    .a_address_o(a_address_o), .w_address_o(w_address_o),
    .a_stride_o(a_stride_o), .w_stride_o(w_stride_o),
    .a_rollback_o(a_rollback_o), .w_rollback_o(w_rollback_o),
    .a_skip_o(a_skip_o), .w_skip_o(w_skip_o),
    .csr_a_rstn_o(csr_a_rstn_o), .csr_w_rstn_o(csr_w_rstn_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sw(input logic acc, input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
    sw_access_i = acc;
    sw_addr_i   = addr;
    sw_op_i     = op;
    sw_wdata_i  = wd;
  endtask

  task automatic hw(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    hw_op_i    = op;
    hw_addr_i  = addr;
    hw_wdata_i = wd;
  endtask

  // Directed stimulus and checks.
  initial begin
    rst_i = 1'b1;
    sw(1'b0, BASE, 2'd0, 32'h0);
    hw(2'd0, BASE, 32'h0);

    // Reset held three cycles.
    tick();
    check("rst_a_rstn_low", {31'b0, csr_a_rstn_o}, 32'd0);
    check("rst_w_rstn_low", {31'b0, csr_w_rstn_o}, 32'd0);
    tick();
    tick();
    check("rst_a_rstn_held", {31'b0, csr_a_rstn_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    check("rel_a_rstn", {31'b0, csr_a_rstn_o}, 32'd1);
    check("rel_w_rstn", {31'b0, csr_w_rstn_o}, 32'd1);
    check("rel_a_addr", a_address_o, 32'h0);
    check("rel_w_skip", w_skip_o, 32'h0);
    sw(1'b0, BASE + 12'd8, 2'd0, 32'h0);
    #1 check("rel_a_cnt", sw_rdata_o, 32'h0);
    sw(1'b0, BASE + 12'd9, 2'd0, 32'h0);
    #1 check("rel_w_cnt", sw_rdata_o, 32'h0);

    // Software WRITE / SET / CLEAR on A_ADDR.
    sw(1'b1, BASE, 2'd1, 32'h1000);
    #1 check("hit_base0", {31'b0, sw_hit_o}, 32'd1);
    tick();
    check("sw_write_a", a_address_o, 32'h1000);
    check("sw_write_strobe", {31'b0, csr_a_rstn_o}, 32'd0);
    sw(1'b1, BASE, 2'd2, 32'h3);
    tick();
    check("sw_set_a", a_address_o, 32'h1003);
    check("sw_set_strobe", {31'b0, csr_a_rstn_o}, 32'd0);
    sw(1'b1, BASE, 2'd3, 32'h1000);
    #1 check("rdata_pre_update", sw_rdata_o, 32'h1003);
    tick();
    check("sw_clear_a", a_address_o, 32'h0003);
    check("sw_clear_strobe", {31'b0, csr_a_rstn_o}, 32'd0);
    sw(1'b0, BASE, 2'd0, 32'h0);
    tick();
    check("strobe_release", {31'b0, csr_a_rstn_o}, 32'd1);

    // Hardware updates to W_ADDR.
    sw(1'b1, BASE + 12'd1, 2'd1, 32'h2000);
    tick();
    check("w_preload", w_address_o, 32'h2000);
    sw(1'b0, BASE, 2'd0, 32'h0);
    hw(2'd1, BASE + 12'd1, 32'h2010);
    tick();
    check("hw_w_1", w_address_o, 32'h2010);
    check("hw_w_no_strobe", {31'b0, csr_w_rstn_o}, 32'd1);
    hw(2'd1, BASE + 12'd1, 32'h2020);
    tick();
    check("hw_w_2", w_address_o, 32'h2020);
    hw(2'd1, BASE + 12'd1, 32'h1FF4);
    tick();
    check("hw_w_3", w_address_o, 32'h1FF4);
    check("hw_w_no_strobe3", {31'b0, csr_w_rstn_o}, 32'd1);
    hw(2'd0, BASE, 32'h0);
    sw(1'b0, BASE + 12'd9, 2'd0, 32'h0);
    #1 check("w_upd_cnt3", sw_rdata_o, 32'd3);

    // Collision on A_ADDR: software wins, no count.
    sw(1'b1, BASE, 2'd1, 32'h5000);
    hw(2'd1, BASE, 32'h6000);
    tick();
    check("collide_a", a_address_o, 32'h5000);
    check("collide_strobe", {31'b0, csr_a_rstn_o}, 32'd0);
    sw(1'b0, BASE + 12'd8, 2'd0, 32'h0);
    hw(2'd0, BASE, 32'h0);
    #1 check("collide_cnt", sw_rdata_o, 32'd0);
    tick();
    check("collide_strobe_end", {31'b0, csr_a_rstn_o}, 32'd1);

    // Different registers in the same cycle.
    sw(1'b1, BASE + 12'd7, 2'd1, 32'h7);
    hw(2'd1, BASE, 32'h44);
    tick();
    check("par_w_skip", w_skip_o, 32'h7);
    check("par_a_addr", a_address_o, 32'h44);
    check("par_w_strobe", {31'b0, csr_w_rstn_o}, 32'd0);
    check("par_a_strobe", {31'b0, csr_a_rstn_o}, 32'd1);
    sw(1'b0, BASE + 12'd8, 2'd0, 32'h0);
    hw(2'd0, BASE, 32'h0);
    #1 check("par_a_cnt", sw_rdata_o, 32'd1);

    // Read-only count and out-of-range accesses.
    sw(1'b1, BASE + 12'd8, 2'd1, 32'h55);
    tick();
    sw(1'b0, BASE + 12'd8, 2'd0, 32'h0);
    #1 check("ro_cnt", sw_rdata_o, 32'd1);
    check("ro_no_strobe", {31'b0, csr_a_rstn_o}, 32'd1);
    sw(1'b1, BASE + 12'd10, 2'd1, 32'hFFFF);
    #1 check("oor_hit", {31'b0, sw_hit_o}, 32'd0);
    check("oor_rdata", sw_rdata_o, 32'd0);
    tick();
    check("oor_no_change_a", a_address_o, 32'h44);

    // Stride write: no strobe.
    sw(1'b1, BASE + 12'd2, 2'd1, 32'hAB);
    tick();
    check("stride_a", a_stride_o, 32'hAB);
    check("stride_no_strobe", {31'b0, csr_a_rstn_o}, 32'd1);
    sw(1'b0, BASE, 2'd0, 32'h0);

    // Non-WRITE controller op and out-of-range controller address ignored.
    hw(2'd2, BASE, 32'h1234);
    tick();
    check("hw_op_ignored", a_address_o, 32'h44);
    hw(2'd1, BASE + 12'd2, 32'h1234);
    tick();
    check("hw_addr_ignored", a_stride_o, 32'hAB);
    hw(2'd0, BASE, 32'h0);

    // Count wrap: preload A_UPD_CNT to all ones, then one more update.
    force dut.a_cnt_q = 32'hFFFFFFFF;
    #1 release dut.a_cnt_q;
    hw(2'd1, BASE, 32'h99);
    tick();
    hw(2'd0, BASE, 32'h0);
    sw(1'b0, BASE + 12'd8, 2'd0, 32'h0);
    #1 check("cnt_wrap", sw_rdata_o, 32'd0);
    check("wrap_a_addr", a_address_o, 32'h99);

    // Reset during a write: write lost.
    sw(1'b1, BASE + 12'd4, 2'd1, 32'hDEAD);
    rst_i = 1'b1;
    tick();
    check("rst_wins", a_rollback_o, 32'h0);
    check("rst_clears_a", a_address_o, 32'h0);
    rst_i = 1'b0;
    sw(1'b0, BASE, 2'd0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/macload_csr_regs.md
# macload_csr_regs

Register bank and update responder for the MAC-load address generator. Holds activation/weight address, stride, rollback and skip registers. Accepts software CSR accesses from the CSR instruction path and autonomous address-write requests from the MAC-load controller. Feeds current register values back to that controller, and emits one-cycle counter-reset strobes whenever software re-programs an address or skip value.

## Interface
Parameters:
- BASE_ADDR, 12'h7D0, CSR address of register offset 0; the block decodes BASE_ADDR+0 to BASE_ADDR+9.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- sw_access_i  in  1  software CSR access valid
- sw_addr_i  in  12  software CSR address
- sw_op_i  in  2  0 NONE, 1 WRITE, 2 SET, 3 CLEAR
- sw_wdata_i  in  32  software write/set/clear operand
- sw_rdata_o  out  32  read data for sw_addr_i (combinational)
- sw_hit_o  out  1  sw_addr_i lies in BASE_ADDR..BASE_ADDR+9 (combinational)
- hw_op_i  in  2  controller op; only WRITE (1) honoured
- hw_addr_i  in  12  controller target, BASE_ADDR+0 or +1 only
- hw_wdata_i  in  32  controller updated address
- a_address_o, w_address_o  out  32  register contents
- a_stride_o, w_stride_o  out  32  register contents
- a_rollback_o, w_rollback_o  out  32  register contents
- a_skip_o, w_skip_o  out  32  register contents
- csr_a_rstn_o, csr_w_rstn_o  out  1  active-low counter-reset strobes to the controller

## Operation
- Register map by offset from BASE_ADDR:
  - 0 A_ADDR, 1 W_ADDR
  - 2 A_STRIDE, 3 W_STRIDE
  - 4 A_ROLLBACK, 5 W_ROLLBACK
  - 6 A_SKIP, 7 W_SKIP
  - 8 A_UPD_CNT (read-only), 9 W_UPD_CNT (read-only)
- Software access is active when sw_access_i=1, sw_hit_o=1 and sw_op_i≠NONE.
  - WRITE: reg ← wdata.
  - SET: reg ← reg | wdata.
  - CLEAR: reg ← reg & ~wdata.
  - Accesses to offsets 8 and 9 are ignored. Out-of-range addresses are ignored and return rdata 0.
- sw_rdata_o always returns the pre-update register value in the access cycle.
- Hardware update: when hw_op_i=WRITE and hw_addr_i is offset 0 or 1, the target register ← hw_wdata_i. The matching UPD_CNT increments by 1, wrapping 0xFFFFFFFF→0.
  - Any other hw_op_i or hw_addr_i value is ignored, with no count.
- Collision: if software and hardware target the same register in the same cycle, software wins. The hardware write is dropped and its UPD_CNT does not increment.
- Different registers accessed in the same cycle are both applied.
- Strobes: csr_a_rstn_o is registered. It goes low for exactly one cycle, the cycle after any active software access to A_ADDR or A_SKIP.
  - The W side behaves identically for W_ADDR and W_SKIP.
  - Software accesses to STRIDE or ROLLBACK registers do not strobe.
  - Back-to-back qualifying accesses hold the strobe low for consecutive cycles.
- Hardware writes never generate strobes.

## Timing
- Reset (rst_i=1 at an edge):
  - All 10 registers become 0.
  - csr_a_rstn_o and csr_w_rstn_o become 0, and stay 0 while rst_i is held.
  - Both strobes return to 1 on the first edge with rst_i=0.
- Reset asserted during a write: reset wins and the write is lost.
- Register writes and counter increments are visible on the outputs the cycle after the access edge (1-cycle latency).
- A strobe and the new register value become visible in the same cycle.
- A hardware update arriving in a strobe-low cycle is applied normally.
- No stalls and no backpressure: every access completes in one cycle.

## Test plan
- Reset with rst_i held 3 cycles, then released → all register outputs and both UPD_CNT read 0; strobes 0 during reset and 1 in the first cycle after release.
- Software WRITE 0x1000 to BASE+0, next cycle SET 0x3 and then CLEAR 0x1000 → a_address_o reads 0x1000, then 0x1003, then 0x0003; csr_a_rstn_o low for 3 consecutive cycles.
- With w_address_o=0x2000, three hardware WRITEs to BASE+1 with 0x2010, 0x2020, 0x1FF4 → w_address_o follows each value one cycle later; W_UPD_CNT reads 3; csr_w_rstn_o stays 1.
- Same-cycle software WRITE 0x5000 and hardware WRITE 0x6000, both to BASE+0 → a_address_o = 0x5000; A_UPD_CNT unchanged; csr_a_rstn_o low one cycle.
- Same-cycle software WRITE 0x7 to BASE+7 and hardware WRITE 0x44 to BASE+0 → w_skip_o=7, a_address_o=0x44, A_UPD_CNT+1, csr_w_rstn_o low one cycle, csr_a_rstn_o stays 1.
- Software WRITE to BASE+8, then an access to BASE+10 → A_UPD_CNT unchanged; sw_hit_o=0 and rdata=0 for BASE+10; preload A_UPD_CNT to 0xFFFFFFFF via hardware updates (or force) and issue one more hardware update → count wraps to 0.
